bas_search_fsm: RTL and testbench



---
 rtl/bas_search_fsm_if.sv | 13 +
 rtl/bas_search_fsm.sv | 249 ++++++++++++++++++++++++
 tb/tb_bas_search_fsm.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bas_search_fsm_if.sv
// Direction-vector handshake between the random direction source and the BAS engine.
// master = direction source, slave = optimiser engine.
interface bas_search_fsm_if #(
  parameter int unsigned FRAC = 8
) ();
  logic                   dir_valid;
  logic                   dir_ready;
  logic signed [FRAC:0]   dir_x;
  logic signed [FRAC:0]   dir_y;

  modport master (output dir_valid, dir_x, dir_y, input dir_ready);
  modport slave  (input dir_valid, dir_x, dir_y, output dir_ready);
endinterface

// File: rtl/bas_search_fsm.sv
// Beetle Antennae Search engine minimising the Booth cost in signed fixed point; one shared
// cost evaluator is time-multiplexed over the centre, left and right antenna points.
module bas_search_fsm #(
  parameter int unsigned W      = 16,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned STEP_W = 14,
  parameter int unsigned ITER_W = 10,
  parameter int unsigned CW     = 40
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [W-1:0]      x0,
  input  logic signed [W-1:0]      y0,
  input  logic        [STEP_W-1:0] sense0,
  input  logic        [STEP_W-1:0] move0,
  input  logic        [FRAC:0]     decay,
  input  logic        [ITER_W-1:0] iterations,
  input  logic signed [CW-1:0]     threshold,
  bas_search_fsm_if.slave          dir,
  output logic                     busy,
  output logic                     done,
  output logic signed [W-1:0]      best_x,
  output logic signed [W-1:0]      best_y,
  output logic signed [CW-1:0]     best_cost,
  output logic        [ITER_W-1:0] iter_count
);

  localparam int unsigned PW = STEP_W + FRAC + 2;   // signed step * direction product
  localparam int unsigned OW = PW - FRAC;           // scaled offset
  localparam int unsigned SW = ((W > OW) ? W : OW) + 1;
  localparam int unsigned AW = W + 3;
  localparam int unsigned QW = 2 * AW;
  localparam int unsigned DW = STEP_W + FRAC + 1;
  localparam int          Seven = 7 * (2 ** FRAC);
  localparam int          Five  = 5 * (2 ** FRAC);

  localparam logic signed [W-1:0]  CoordMax = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  CoordMin = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [CW-1:0] CostMax  = {1'b0, {(CW-1){1'b1}}};

  typedef enum logic [2:0] {
    StIdle, StWaitDir, StEvalC, StEvalL, StEvalR, StUpdate, StDone
  } state_e;

  function automatic logic signed [OW-1:0] scale(input logic [STEP_W-1:0] len,
                                                 input logic signed [FRAC:0] d);
    logic signed [PW-1:0] p;
    p = PW'($signed({1'b0, len})) * PW'(d);
    return OW'(p >>> FRAC);
  endfunction

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0]  c,
                                                  input logic signed [OW-1:0] o,
                                                  input logic                 sub);
    logic signed [SW-1:0] s;
    s = sub ? (SW'(c) - SW'(o)) : (SW'(c) + SW'(o));
    if (s > SW'(CoordMax)) return CoordMax;
    if (s < SW'(CoordMin)) return CoordMin;
    return W'(s);
  endfunction

  function automatic logic signed [CW-1:0] cost(input logic signed [W-1:0] x,
                                                input logic signed [W-1:0] y);
    logic signed [AW-1:0] a, b;
    logic signed [QW-1:0] aa, bb;
    a  = AW'(x) + (AW'(y) <<< 1) - AW'(Seven);
    b  = (AW'(x) <<< 1) + AW'(y) - AW'(Five);
    aa = QW'(a) * QW'(a);
    bb = QW'(b) * QW'(b);
    return CW'(aa >>> FRAC) + CW'(bb >>> FRAC);
  endfunction

  // Lengths above the representable range clamp rather than wrap when decay exceeds 1.0.
  function automatic logic [STEP_W-1:0] decay_len(input logic [STEP_W-1:0] len,
                                                  input logic [FRAC:0]     d);
    logic [DW-1:0] p;
    p = (DW'(len) * DW'(d)) >> FRAC;
    return (|p[DW-1:STEP_W]) ? {STEP_W{1'b1}} : p[STEP_W-1:0];
  endfunction

  state_e                    state_q, state_d;
  logic signed [W-1:0]       cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        [STEP_W-1:0]  sense_q, sense_d, move_q, move_d;
  logic        [FRAC:0]      decay_q, decay_d;
  logic        [ITER_W-1:0]  iter_max_q, iter_max_d, iter_q, iter_d;
  logic signed [CW-1:0]      thresh_q, thresh_d;
  logic signed [FRAC:0]      dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic signed [CW-1:0]      fl_q, fl_d, fr_q, fr_d;
  logic signed [W-1:0]       best_x_q, best_x_d, best_y_q, best_y_d;
  logic signed [CW-1:0]      best_cost_q, best_cost_d;
  logic                      busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic signed [OW-1:0]      sense_off_x, sense_off_y, move_off_x, move_off_y;
  logic signed [W-1:0]       eval_x, eval_y;
  logic signed [CW-1:0]      f_eval;
  logic                      go_right;

  assign sense_off_x = scale(sense_q, dir_x_q);
  assign sense_off_y = scale(sense_q, dir_y_q);
  assign move_off_x  = scale(move_q, dir_x_q);
  assign move_off_y  = scale(move_q, dir_y_q);
  assign go_right    = !(fl_q < fr_q);

  always_comb begin
    eval_x = cur_x_q;
    eval_y = cur_y_q;
    if (state_q == StEvalL) begin
      eval_x = sat_add(cur_x_q, sense_off_x, 1'b0);
      eval_y = sat_add(cur_y_q, sense_off_y, 1'b0);
    end else if (state_q == StEvalR) begin
      eval_x = sat_add(cur_x_q, sense_off_x, 1'b1);
      eval_y = sat_add(cur_y_q, sense_off_y, 1'b1);
    end
  end

  assign f_eval = cost(eval_x, eval_y);

  always_comb begin
    state_d     = state_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    sense_d     = sense_q;
    move_d      = move_q;
    decay_d     = decay_q;
    iter_max_d  = iter_max_q;
    thresh_d    = thresh_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    fl_d        = fl_q;
    fr_d        = fr_q;
    best_x_d    = best_x_q;
    best_y_d    = best_y_q;
    best_cost_d = best_cost_q;
    iter_d      = iter_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cur_x_d     = x0;
          cur_y_d     = y0;
          sense_d     = sense0;
          move_d      = move0;
          decay_d     = decay;
          iter_max_d  = iterations;
          thresh_d    = threshold;
          iter_d      = '0;
          best_x_d    = x0;
          best_y_d    = y0;
          best_cost_d = CostMax;
          state_d     = (iterations == '0) ? StDone : StWaitDir;
        end
      end
      StWaitDir: begin
        if (dir.dir_valid) begin
          dir_x_d = dir.dir_x;
          dir_y_d = dir.dir_y;
          state_d = StEvalC;
        end
      end
      StEvalC: begin
        if (f_eval < best_cost_q) begin
          best_cost_d = f_eval;
          best_x_d    = cur_x_q;
          best_y_d    = cur_y_q;
        end
        state_d = StEvalL;
      end
      StEvalL: begin
        fl_d    = f_eval;
        state_d = StEvalR;
      end
      StEvalR: begin
        fr_d    = f_eval;
        state_d = StUpdate;
      end
      StUpdate: begin
        cur_x_d = sat_add(cur_x_q, move_off_x, go_right);
        cur_y_d = sat_add(cur_y_q, move_off_y, go_right);
        sense_d = decay_len(sense_q, decay_q);
        move_d  = decay_len(move_q, decay_q);
        iter_d  = iter_q + ITER_W'(1);
        state_d = ((iter_d == iter_max_q) || (best_cost_q <= thresh_q)) ? StDone : StWaitDir;
      end
      default: state_d = StIdle;
    endcase

    // Abort lets the current state commit its updates, then ends the run.
    if (abort && busy_q) state_d = StDone;

    busy_d  = (state_d != StIdle) && (state_d != StDone);
    done_d  = (state_d == StDone);
    ready_d = (state_d == StWaitDir);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      sense_q     <= '0;
      move_q      <= '0;
      decay_q     <= '0;
      iter_max_q  <= '0;
      thresh_q    <= '0;
      dir_x_q     <= '0;
      dir_y_q     <= '0;
      fl_q        <= '0;
      fr_q        <= '0;
      best_x_q    <= '0;
      best_y_q    <= '0;
      best_cost_q <= CostMax;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      sense_q     <= sense_d;
      move_q      <= move_d;
      decay_q     <= decay_d;
      iter_max_q  <= iter_max_d;
      thresh_q    <= thresh_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      fl_q        <= fl_d;
      fr_q        <= fr_d;
      best_x_q    <= best_x_d;
      best_y_q    <= best_y_d;
      best_cost_q <= best_cost_d;
      iter_q      <= iter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign dir.dir_ready = ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_x        = best_x_q;
  assign best_y        = best_y_q;
  assign best_cost     = best_cost_q;
  assign iter_count    = iter_q;

endmodule

// File: tb/tb_bas_search_fsm.sv
// Randomised bench for bas_search_fsm: every run is replayed through an integer model of the
// BAS algorithm and the final best point, cost and iteration count are compared.
module tb_bas_search_fsm;
  localparam int unsigned W = 16, FRAC = 8, STEP_W = 14, ITER_W = 10, CW = 40;
  localparam int unsigned DirW = FRAC + 1;
  localparam longint CostMax = (64'sd1 <<< (CW - 1)) - 64'sd1;
  localparam longint StepMax = (64'sd1 <<< STEP_W) - 64'sd1;

  logic clock = 1'b0;
  logic reset, start, abort;
  logic signed [W-1:0]  x0, y0;
  logic [STEP_W-1:0]    sense0, move0;
  logic [FRAC:0]        decay;
  logic [ITER_W-1:0]    iterations;
  logic signed [CW-1:0] threshold;
  logic                 busy, done;
  logic signed [W-1:0]  best_x, best_y;
  logic signed [CW-1:0] best_cost;
  logic [ITER_W-1:0]    iter_count;

  bas_search_fsm_if #(.FRAC(FRAC)) dif ();

  bas_search_fsm #(.W(W), .FRAC(FRAC), .STEP_W(STEP_W), .ITER_W(ITER_W), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .x0(x0), .y0(y0),
    .sense0(sense0), .move0(move0), .decay(decay), .iterations(iterations),
    .threshold(threshold), .dir(dif), .busy(busy), .done(done), .best_x(best_x),
    .best_y(best_y), .best_cost(best_cost), .iter_count(iter_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  longint cfg_x0, cfg_y0, cfg_sense, cfg_move, cfg_decay, cfg_thr;
  int     cfg_iters;
  int     dqx[$], dqy[$];
  longint exp_bx, exp_by, exp_bc;
  int     exp_it;
  int     cycles, abort_cyc;
  bit     saw_ready;
  longint sense_tr[$], move_tr[$];

  function automatic longint clamp(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint booth(input longint x, input longint y);
    longint a, b;
    a = x + 2 * y - 7 * 256;
    b = 2 * x + y - 5 * 256;
    return ((a * a) >>> 8) + ((b * b) >>> 8);
  endfunction

  // Reference: lim caps how many iterations complete before an abort.
  task automatic model_run(input int lim);
    longint cx, cy, s, m, bx, by, bc, fc, fl, fr, ox, oy;
    int it;
    cx = cfg_x0; cy = cfg_y0; s = cfg_sense; m = cfg_move;
    bx = cx; by = cy; bc = CostMax; it = 0;
    if (cfg_iters != 0) begin
      while (it < lim) begin
        fc = booth(cx, cy);
        if (fc < bc) begin bc = fc; bx = cx; by = cy; end
        ox = (s * dqx[it]) >>> 8;
        oy = (s * dqy[it]) >>> 8;
        fl = booth(clamp(cx + ox), clamp(cy + oy));
        fr = booth(clamp(cx - ox), clamp(cy - oy));
        ox = (m * dqx[it]) >>> 8;
        oy = (m * dqy[it]) >>> 8;
        if (fl < fr) begin cx = clamp(cx + ox); cy = clamp(cy + oy); end
        else begin cx = clamp(cx - ox); cy = clamp(cy - oy); end
        s = (s * cfg_decay) >> 8; if (s > StepMax) s = StepMax;
        m = (m * cfg_decay) >> 8; if (m > StepMax) m = StepMax;
        it++;
        if (it == cfg_iters || bc <= cfg_thr) break;
      end
    end
    exp_bx = bx; exp_by = by; exp_bc = bc; exp_it = it;
  endtask

  task automatic load_dirs(input int n, input bit fixed, input int fx, input int fy);
    dqx.delete(); dqy.delete();
    for (int i = 0; i < n; i++) begin
      dqx.push_back(fixed ? fx : int'($urandom_range(0, 511)) - 256);
      dqy.push_back(fixed ? fy : int'($urandom_range(0, 511)) - 256);
    end
  endtask

  task automatic random_cfg();
    bit wide;
    wide      = ($urandom_range(0, 3) == 0);
    cfg_x0    = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4095)) - 2048;
    cfg_y0    = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4095)) - 2048;
    cfg_sense = $urandom_range(0, 16383);
    cfg_move  = $urandom_range(0, 16383);
    cfg_decay = $urandom_range(0, 511);
    cfg_iters = $urandom_range(1, 8);
    cfg_thr   = ($urandom_range(0, 2) == 0) ? longint'($urandom_range(0, 65535)) : -1;
    load_dirs(cfg_iters, 1'b0, 0, 0);
  endtask

  // Starts a run at a negedge and services the direction handshake until done or timeout.
  task automatic run_search(input int abort_at, input int stall_at, input bit rand_valid);
    int idx, stall_cnt, last_it;
    bit pend;
    idx = 0; stall_cnt = 0; last_it = 0; pend = 0; abort_cyc = -1;
    x0 = W'(cfg_x0); y0 = W'(cfg_y0);
    sense0 = STEP_W'(cfg_sense); move0 = STEP_W'(cfg_move);
    decay = DirW'(cfg_decay); iterations = ITER_W'(cfg_iters); threshold = CW'(cfg_thr);
    saw_ready = 0; sense_tr.delete(); move_tr.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0; cycles = 1;
    while (!done && cycles < 3000) begin
      if (pend) idx++;
      if (dif.dir_ready) saw_ready = 1;
      pend = 0; dif.dir_valid = 1'b0;
      if (dif.dir_ready && idx == abort_at) begin
        abort = 1'b1; abort_cyc = cycles;
      end else if (dif.dir_ready && idx == stall_at && stall_cnt < 20) begin
        stall_cnt++;
        if (stall_cnt == 20) begin
          check("stall_iter", iter_count, stall_at);
          check("stall_busy", busy, 1);
          check("stall_ready", dif.dir_ready, 1);
          check("stall_done", done, 0);
        end
      end else if (idx < dqx.size() && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        dif.dir_valid = 1'b1;
        dif.dir_x = DirW'(dqx[idx]);
        dif.dir_y = DirW'(dqy[idx]);
        pend = dif.dir_ready;
      end
      @(negedge clock);
      cycles++;
      if (int'(iter_count) != last_it) begin
        last_it = int'(iter_count);
        sense_tr.push_back(longint'(dut.sense_q));
        move_tr.push_back(longint'(dut.move_q));
      end
    end
    abort = 1'b0; dif.dir_valid = 1'b0;
    check("run_timeout", done, 1);
  endtask

  task automatic check_model(input string tag, input int lim);
    model_run(lim);
    check({tag, "_best_x"}, best_x, exp_bx);
    check({tag, "_best_y"}, best_y, exp_by);
    check({tag, "_cost"}, best_cost, exp_bc);
    check({tag, "_iter"}, iter_count, exp_it);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, dif.dir_ready, 0);
    check({tag, "_iter"}, iter_count, 0);
    check({tag, "_bx"}, best_x, 0);
    check({tag, "_by"}, best_y, 0);
    check({tag, "_cost"}, best_cost, CostMax);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    x0 = '0; y0 = '0; sense0 = '0; move0 = '0; decay = '0; iterations = '0; threshold = '0;
    dif.dir_valid = 1'b0; dif.dir_x = '0; dif.dir_y = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_reset_vals("reset");

    // Zero iterations finishes immediately without asking for a direction.
    cfg_x0 = 256; cfg_y0 = 768; cfg_sense = 256; cfg_move = 256; cfg_decay = 256;
    cfg_iters = 0; cfg_thr = 0; load_dirs(0, 1'b1, 0, 0);
    run_search(-1, -1, 1'b0);
    check("zero_cycles", cycles, 1);
    check("zero_ready_seen", saw_ready, 0);
    check("zero_bx", best_x, 256);
    check("zero_by", best_y, 768);
    check("zero_cost", best_cost, CostMax);
    check("zero_iter", iter_count, 0);

    // Start on the global minimum with threshold 0: one iteration then stop.
    cfg_iters = 10; cfg_thr = 0; load_dirs(10, 1'b1, 255, 0);
    run_search(-1, -1, 1'b0);
    check("gmin_cycles", cycles, 6);
    check("gmin_cost", best_cost, 0);
    check("gmin_iter", iter_count, 1);
    check("gmin_bx", best_x, 256);
    check_model("gmin", 100);

    // Single step from the origin with direction (-1.0, 0).
    cfg_x0 = 0; cfg_y0 = 0; cfg_iters = 1; cfg_thr = -1; load_dirs(1, 1'b1, -256, 0);
    run_search(-1, -1, 1'b0);
    check("step_cycles", cycles, 6);
    check("step_cost", best_cost, 64'h4A00);
    check("step_cur_x", dut.cur_x_q, 256);
    check_model("step", 100);

    // Halving decay.
    cfg_x0 = 512; cfg_y0 = -256; cfg_sense = 'h1900; cfg_move = 'h1900; cfg_decay = 'h80;
    cfg_iters = 2; cfg_thr = -1; load_dirs(2, 1'b0, 0, 0);
    run_search(-1, -1, 1'b0);
    check("decay_trace_len", sense_tr.size(), 2);
    if (sense_tr.size() == 2 && move_tr.size() == 2) begin
      check("decay_sense1", sense_tr[0], 'h0C80);
      check("decay_move1", move_tr[0], 'h0C80);
      check("decay_sense2", sense_tr[1], 'h0640);
      check("decay_move2", move_tr[1], 'h0640);
    end
    check_model("decay", 100);

    // 20-cycle stall after the first iteration.
    random_cfg(); cfg_iters = 3; cfg_thr = -1; load_dirs(3, 1'b0, 0, 0);
    run_search(-1, 1, 1'b0);
    check_model("stall", 100);

    // Abort while waiting for the third direction.
    random_cfg(); cfg_iters = 6; cfg_thr = -1; load_dirs(6, 1'b0, 0, 0);
    run_search(2, -1, 1'b1);
    check("abort_latency", cycles - abort_cyc, 1);
    check_model("abort", 2);

    // Reset while the engine is in the left-antenna evaluation.
    x0 = 16'sd100; y0 = -16'sd50; sense0 = 14'd300; move0 = 14'd300; decay = 9'd256;
    iterations = 10'd3; threshold = -40'sd1;
    dif.dir_valid = 1'b1; dif.dir_x = 9'sd100; dif.dir_y = -9'sd40;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; dif.dir_valid = 1'b0;
    check_reset_vals("midreset");

    for (int r = 0; r < 25; r++) begin
      random_cfg();
      run_search(-1, -1, 1'b1);
      check_model($sformatf("rand%0d", r), 100);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
